fm_sample_modulator: RTL and testbench



---
 rtl/fm_sample_modulator.sv | 157 +++++++++++++++
 tb/tb_fm_sample_modulator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_sample_modulator.sv
// FM modulation front end: paces sample ROM reads with a rate divider and streams
// carrier plus scaled-sample phase increments to a DDS.
module fm_sample_modulator #(
  parameter int unsigned       SAMPLE_W     = 16,
  parameter int unsigned       ADDR_W       = 10,
  parameter int unsigned       PINC_W       = 40,
  parameter int unsigned       DIV          = 64,
  parameter logic [PINC_W-1:0] CARRIER_PINC = 40'h0A00000000,
  parameter int unsigned       DEV_SHIFT    = 8
) (
  input  logic                clk_in1,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_mode,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_dout,
  output logic                m_pinc_tvalid,
  output logic [PINC_W-1:0]   m_pinc_tdata,
  output logic                sample_tick,
  output logic                busy,
  output logic                done
);

  localparam int unsigned      DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nx;
  logic [DIV_W-1:0]    div_cnt, div_nx, div_inc;
  logic [ADDR_W-1:0]   win_start, win_start_nx, win_end, win_end_nx;
  logic                win_loop, win_loop_nx;
  logic                eod, eod_nx;
  logic                rd_valid, rd_valid_nx;
  logic                rom_en_nx, sample_tick_nx, busy_nx, done_nx, tvalid_nx;
  logic [ADDR_W-1:0]   rom_addr_nx;
  logic [PINC_W-1:0]   tdata_nx, pinc_c;
  logic signed [PINC_W-1:0] sample_ext;

  // Sign-extend before shifting; the sum wraps modulo 2^PINC_W
  assign sample_ext = PINC_W'($signed(rom_dout));
  assign pinc_c     = CARRIER_PINC + (sample_ext <<< DEV_SHIFT);
  assign div_inc    = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      win_start     <= '0;
      win_end       <= '0;
      win_loop      <= 1'b0;
      eod           <= 1'b0;
      rd_valid      <= 1'b0;
      rom_en        <= 1'b0;
      rom_addr      <= '0;
      sample_tick   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_pinc_tvalid <= 1'b0;
      m_pinc_tdata  <= CARRIER_PINC;
    end else begin
      state         <= state_nx;
      div_cnt       <= div_nx;
      win_start     <= win_start_nx;
      win_end       <= win_end_nx;
      win_loop      <= win_loop_nx;
      eod           <= eod_nx;
      rd_valid      <= rd_valid_nx;
      rom_en        <= rom_en_nx;
      rom_addr      <= rom_addr_nx;
      sample_tick   <= sample_tick_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      m_pinc_tvalid <= tvalid_nx;
      m_pinc_tdata  <= tdata_nx;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop
  always_comb begin
    state_nx       = state;
    div_nx         = div_cnt;
    win_start_nx   = win_start;
    win_end_nx     = win_end;
    win_loop_nx    = win_loop;
    eod_nx         = eod;
    rd_valid_nx    = rom_en;
    rom_en_nx      = 1'b0;
    sample_tick_nx = 1'b0;
    done_nx        = 1'b0;
    rom_addr_nx    = rom_addr;
    tvalid_nx      = m_pinc_tvalid;
    tdata_nx       = m_pinc_tdata;

    if (rom_en) begin
      if (rom_addr == win_end) begin
        if (win_loop) rom_addr_nx = win_start;
        else          eod_nx      = 1'b1;
      end else begin
        rom_addr_nx = rom_addr + ADDR_W'(1);
      end
    end

    if (rd_valid) begin
      tdata_nx  = pinc_c;
      tvalid_nx = 1'b1;
    end
    if (done) tdata_nx = CARRIER_PINC;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx       = RUN;
          win_start_nx   = start_addr;
          win_end_nx     = end_addr;
          win_loop_nx    = loop_mode;
          eod_nx         = 1'b0;
          rom_addr_nx    = start_addr;
          div_nx         = DIV_LAST;
          rom_en_nx      = 1'b1;
          sample_tick_nx = 1'b1;
        end
      end
      RUN: begin
        div_nx = div_inc;
        // Next cycle is a tick: read again, or finish a drained one-shot
        if (div_inc == DIV_LAST) begin
          if (eod) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            rom_en_nx      = 1'b1;
            sample_tick_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (stop) begin
      state_nx       = IDLE;
      rom_en_nx      = 1'b0;
      sample_tick_nx = 1'b0;
      done_nx        = 1'b0;
      rd_valid_nx    = 1'b0;
      eod_nx         = 1'b0;
      tdata_nx       = CARRIER_PINC;
    end

    busy_nx = (state_nx == RUN);
  end

endmodule

// File: tb/tb_fm_sample_modulator.sv
// Self-checking bench for fm_sample_modulator: directed vector table, hand sequences
// for stop/reset corners, and randomized windows against a cycle-offset reference model.
module tb_fm_sample_modulator;

  localparam int unsigned DV   = 4;
  localparam int unsigned SH   = 4;
  localparam int unsigned SH2  = 24;
  localparam logic [39:0] CAR  = 40'h0000001000;
  localparam logic [39:0] CAR2 = 40'h0000000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_mode = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [9:0]  end_addr = '0;
  logic        rom_en, sample_tick, busy, done, tvalid;
  logic [9:0]  rom_addr;
  logic [15:0] rom_dout = '0;
  logic [39:0] tdata;
  logic        rom_en2, sample_tick2, busy2, done2, tvalid2;
  logic [9:0]  rom_addr2;
  logic [15:0] rom_dout2 = 16'h8000;
  logic [39:0] tdata2;

  fm_sample_modulator #(.SAMPLE_W(16), .ADDR_W(10), .PINC_W(40), .DIV(DV),
                        .CARRIER_PINC(CAR), .DEV_SHIFT(SH)) u_dut (
    .clk_in1(clk), .reset(reset), .start(start), .stop(stop), .loop_mode(loop_mode),
    .start_addr(start_addr), .end_addr(end_addr), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .m_pinc_tvalid(tvalid), .m_pinc_tdata(tdata),
    .sample_tick(sample_tick), .busy(busy), .done(done));

  fm_sample_modulator #(.SAMPLE_W(16), .ADDR_W(10), .PINC_W(40), .DIV(DV),
                        .CARRIER_PINC(CAR2), .DEV_SHIFT(SH2)) u_dut2 (
    .clk_in1(clk), .reset(reset), .start(start), .stop(stop), .loop_mode(loop_mode),
    .start_addr(start_addr), .end_addr(end_addr), .rom_en(rom_en2), .rom_addr(rom_addr2),
    .rom_dout(rom_dout2), .m_pinc_tvalid(tvalid2), .m_pinc_tdata(tdata2),
    .sample_tick(sample_tick2), .busy(busy2), .done(done2));

  logic [15:0] rom_mem [0:1023];
  always @(posedge clk) if (rom_en) rom_dout <= rom_mem[rom_addr];

  int total = 0;
  int bad = 0;
  bit exp_tv = 1'b0;

  typedef struct {
    logic [9:0]       sa;
    logic [9:0]       ea;
    bit               lp;
    logic [4:0][9:0]  addr;
    logic [3:0][39:0] pinc;
  } dir_t;
  dir_t dir_tab [3];

  task automatic chk(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pinc_of(logic [15:0] s, int unsigned sh, logic [39:0] car);
    longint v;
    v = longint'($signed(s));
    return 40'(longint'(car) + v * (longint'(1) << sh));
  endfunction

  function automatic int win_len(logic [9:0] sa, logic [9:0] ea);
    return ((int'(ea) - int'(sa) + 1024) % 1024) + 1;
  endfunction

  function automatic logic [9:0] addr_of(logic [9:0] sa, int len, int k);
    return 10'((int'(sa) + (k % len)) % 1024);
  endfunction

  task automatic begin_run(input logic [9:0] sa, input logic [9:0] ea, input bit lp);
    start_addr = sa;
    end_addr   = ea;
    loop_mode  = lp;
    start      = 1'b1;
    step();
    start      = 1'b0;
    start_addr = 10'($urandom);
    end_addr   = 10'($urandom);
    loop_mode  = 1'($urandom);
  endtask

  // Offset t counts cycles from start acceptance (t=1 is the first RUN cycle)
  task automatic run_episode(input logic [9:0] sa, input logic [9:0] ea, input bit lp,
                             input int stop_at, input int start_at,
                             output int done_t, output int done_n);
    int len, ncyc, j, m;
    bit stopped, exp_en;
    logic [39:0] exp_pinc;
    len    = win_len(sa, ea);
    ncyc   = (stop_at > 0) ? stop_at + 2 : len * DV + 4;
    done_t = -1;
    done_n = 0;
    begin_run(sa, ea, lp);
    for (int t = 1; t <= ncyc; t++) begin
      stopped = (stop_at > 0) && (t > stop_at);
      if (done === 1'b1) begin
        done_n++;
        if (done_t < 0) done_t = t;
      end
      if (stopped) begin
        chk("stop_busy", t, busy, 0);
        chk("stop_rom_en", t, rom_en, 0);
        chk("stop_tick", t, sample_tick, 0);
        chk("stop_done", t, done, 0);
        chk("stop_pinc", t, tdata, CAR);
      end else begin
        exp_en = ((t - 1) % DV == 0) && (lp || ((t - 1) / DV) < len);
        chk("rom_en", t, rom_en, exp_en);
        chk("tick", t, sample_tick, exp_en);
        chk("done", t, done, !lp && (t == 1 + len * DV));
        chk("busy", t, busy, lp || (t <= len * DV));
        j = (t == 1) ? 0 : (t - 2) / DV + 1;
        if (!lp && j > len - 1) j = len - 1;
        chk("rom_addr", t, rom_addr, addr_of(sa, len, j));
        if (t < 3 || (!lp && t >= 2 + len * DV)) exp_pinc = CAR;
        else begin
          m = (t - 3) / DV;
          exp_pinc = pinc_of(rom_mem[addr_of(sa, len, m)], SH, CAR);
        end
        chk("pinc", t, tdata, exp_pinc);
        if (t >= 3) exp_tv = 1'b1;
      end
      chk("tvalid", t, tvalid, exp_tv);
      if (t == stop_at) stop = 1'b1;
      if (t == start_at) begin
        start      = 1'b1;
        start_addr = 10'($urandom);
        end_addr   = 10'($urandom);
      end
      step();
      stop  = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    int dt, dn, len, stop_at, start_at;
    logic [9:0] sa;
    bit lp;

    for (int i = 0; i < 1024; i++) rom_mem[i] = 16'($urandom);
    rom_mem[0]      = 16'h0010;
    rom_mem[1]      = 16'hFFF0;
    rom_mem[2]      = 16'h0000;
    rom_mem[5]      = 16'h0100;
    rom_mem[10'h3FE] = 16'h0001;
    rom_mem[10'h3FF] = 16'hFFFF;

    // addr[k] at tick k, pinc[m] for sample period m; packed fields listed high index first
    dir_tab[0] = '{10'h000, 10'h002, 1'b1,
                   {10'h001, 10'h000, 10'h002, 10'h001, 10'h000},
                   {40'h1100, 40'h1000, 40'h0F00, 40'h1100}};
    dir_tab[1] = '{10'h3FE, 10'h001, 1'b1,
                   {10'h3FE, 10'h001, 10'h000, 10'h3FF, 10'h3FE},
                   {40'h0F00, 40'h1100, 40'h0FF0, 40'h1010}};
    dir_tab[2] = '{10'h005, 10'h005, 1'b1,
                   {10'h005, 10'h005, 10'h005, 10'h005, 10'h005},
                   {40'h2000, 40'h2000, 40'h2000, 40'h2000}};

    step(); step(); step();
    chk("rst_pinc", 0, tdata, CAR);
    chk("rst_tvalid", 0, tvalid, 0);
    chk("rst_rom_en", 0, rom_en, 0);
    chk("rst_rom_addr", 0, rom_addr, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_tick", 0, sample_tick, 0);
    chk("rst_done", 0, done, 0);
    chk("rst2_pinc", 0, tdata2, CAR2);
    chk("rst2_misc", 0, {rom_en2, rom_addr2, tvalid2, busy2, sample_tick2, done2}, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      begin_run(dir_tab[i].sa, dir_tab[i].ea, dir_tab[i].lp);
      for (int t = 1; t <= 19; t++) begin
        if ((t - 1) % DV == 0) begin
          chk("dir_rom_en", t, rom_en, 1);
          chk("dir_addr", t, rom_addr, dir_tab[i].addr[(t - 1) / DV]);
        end else begin
          chk("dir_rom_en", t, rom_en, 0);
        end
        if (t >= 3 && t <= 18) chk("dir_pinc", t, tdata, dir_tab[i].pinc[(t - 3) / DV]);
        if (i == 0 && t == 3) begin
          chk("wrap40_pinc", t, tdata2, pinc_of(16'h8000, SH2, CAR2));
          chk("wrap40_tvalid", t, tvalid2, 1);
        end
        if (t == 19) begin
          chk("dir_stop_busy", t, busy, 0);
          chk("dir_stop_pinc", t, tdata, CAR);
        end
        if (t == 18) stop = 1'b1;
        step();
        stop = 1'b0;
      end
    end
    exp_tv = 1'b1;

    // One-shot 0..2: done exactly once, N*DIV cycles after the first tick at t=1
    run_episode(10'h000, 10'h002, 1'b0, 0, 0, dt, dn);
    chk("oneshot_done_t", 0, dt, 13);
    chk("oneshot_done_n", 0, dn, 1);

    // Stop one cycle after a read strobe discards that read
    run_episode(10'h000, 10'h002, 1'b1, 6, 0, dt, dn);
    chk("stop_no_done", 0, dn, 0);

    // Start while running is ignored
    run_episode(10'h000, 10'h002, 1'b1, 20, 3, dt, dn);

    // Start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    start_addr = 10'h000;
    end_addr   = 10'h002;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      chk("ss_busy", t, busy, 0);
      chk("ss_rom_en", t, rom_en, 0);
      step();
    end

    // Reset mid-RUN
    begin_run(10'h000, 10'h002, 1'b1);
    for (int t = 1; t < 8; t++) step();
    reset = 1'b1;
    step();
    chk("mr_pinc", 0, tdata, CAR);
    chk("mr_tvalid", 0, tvalid, 0);
    chk("mr_misc", 0, {rom_en, rom_addr, busy, sample_tick, done}, 0);
    chk("mr2_pinc", 0, tdata2, CAR2);
    reset  = 1'b0;
    exp_tv = 1'b0;
    step();

    for (int r = 0; r < 14; r++) begin
      sa  = 10'($urandom);
      len = int'($urandom_range(1, 4));
      lp  = 1'($urandom);
      if (lp) stop_at = int'($urandom_range(1, 3 * len * DV));
      else if ($urandom_range(0, 1) == 1) stop_at = int'($urandom_range(1, len * DV));
      else stop_at = 0;
      start_at = (stop_at == 0 || stop_at > 2) ? int'($urandom_range(1, 2)) : 0;
      run_episode(sa, 10'(int'(sa) + len - 1), lp, stop_at, start_at, dt, dn);
      if (!lp && stop_at == 0) chk("rnd_done_n", r, dn, 1);
      else chk("rnd_no_done", r, dn, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
